// File: rtl/sync_trial_sequencer.sv
// Drives an incrementing test word into a synchronizer under test, waits a fixed settle time,
// then compares the synchronized word and accumulates trial and error statistics.
module sync_trial_sequencer #(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] trial_count,
    input  logic [WIDTH-1:0] capture_data,
    output logic [WIDTH-1:0] launch_data,
    output logic             launch_en,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] trials_done,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_trial
);

    typedef enum logic [2:0] {StIdle, StLaunch, StSettle, StCheck, StDone} state_e;

    localparam logic [3:0]       SettleLoad = 4'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntMax     = '1;

    state_e           state_q, state_d;
    logic [3:0]       settle_q, settle_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] trials_q, trials_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] first_q, first_d;
    logic [WIDTH-1:0] launch_q, launch_d;
    logic             aborted_q, aborted_d;
    logic [CNT_W-1:0] trials_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            settle_q  <= '0;
            count_q   <= '0;
            trials_q  <= '0;
            err_q     <= '0;
            first_q   <= '0;
            launch_q  <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            count_q   <= count_d;
            trials_q  <= trials_d;
            err_q     <= err_d;
            first_q   <= first_d;
            launch_q  <= launch_d;
            aborted_q <= aborted_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        count_d    = count_q;
        trials_d   = trials_q;
        err_d      = err_q;
        first_d    = first_q;
        launch_d   = launch_q;
        aborted_d  = aborted_q;
        trials_inc = trials_q + CNT_W'(1);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    count_d   = trial_count;
                    trials_d  = '0;
                    err_d     = '0;
                    first_d   = '0;
                    launch_d  = '0;
                    aborted_d = 1'b0;
                    state_d   = (trial_count != '0) ? StLaunch : StDone;
                end
            end
            StLaunch: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    launch_d = launch_q + WIDTH'(1);
                    settle_d = SettleLoad;
                    state_d  = StSettle;
                end
            end
            StSettle: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = StDone;
                end else if (settle_q == '0) begin
                    state_d = StCheck;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            StCheck: begin
                // An aborted check is discarded entirely, so statistics stay untouched.
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    if (capture_data != launch_q) begin
                        if (err_q != CntMax) begin
                            err_d = err_q + CNT_W'(1);
                        end
                        if (err_q == '0) begin
                            first_d = trials_q;
                        end
                    end
                    trials_d = trials_inc;
                    state_d  = (trials_inc == count_q) ? StDone : StLaunch;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        launch_en       = (state_q == StLaunch);
        busy            = (state_q != StIdle);
        done            = (state_q == StDone);
        launch_data     = launch_q;
        aborted         = aborted_q;
        trials_done     = trials_q;
        err_count       = err_q;
        first_err_trial = first_q;
    end

endmodule

// File: tb/tb_sync_trial_sequencer.sv
// Bench for sync_trial_sequencer: directed table rows, hand-written reset sequence, and random
// runs checked against a trial-level model of the run outcome.
module tb_sync_trial_sequencer;

    localparam int W  = 4;
    localparam int CW = 16;
    localparam int S  = 2;
    localparam int P  = S + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] trial_count = '0;
    logic [W-1:0]  capture_data = '0;
    logic [W-1:0]  launch_data;
    logic          launch_en, busy, done, aborted;
    logic [CW-1:0] trials_done, err_count, first_err_trial;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sync_trial_sequencer #(.WIDTH(W), .CNT_W(CW), .SETTLE_CYCLES(S)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .trial_count     (trial_count),
        .capture_data    (capture_data),
        .launch_data     (launch_data),
        .launch_en       (launch_en),
        .busy            (busy),
        .done            (done),
        .aborted         (aborted),
        .trials_done     (trials_done),
        .err_count       (err_count),
        .first_err_trial (first_err_trial)
    );

    typedef struct {
        int          cnt;
        bit          zero_mode;
        logic [63:0] badm;
        int          abort_at;
        int          busy_start_at;
        bit          abort_with_start;
        int          exp_trials;
        int          exp_err;
        int          exp_first;
        bit          exp_aborted;
    } vec_t;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    // Outcome of a run from trial-level rules: abort index -> trial cut, per-trial mismatch.
    function automatic void model(input vec_t v, output int tr, output int er, output int fi,
                                  output bit ab, output int dj, output int ln);
        int t;
        bit mism;
        if (v.cnt > 0 && v.abort_at >= 0 && v.abort_at < P * v.cnt) begin
            ab = 1'b1;
            t  = v.abort_at / P;
            dj = v.abort_at + 1;
            ln = t + 1;
        end else begin
            ab = 1'b0;
            t  = v.cnt;
            dj = P * v.cnt;
            ln = v.cnt;
        end
        tr = t;
        er = 0;
        fi = 0;
        for (int k = 0; k < t; k++) begin
            mism = v.zero_mode ? (((k + 1) % (1 << W)) != 0) : (k < 64 && v.badm[k]);
            if (mism) begin
                if (er == 0) fi = k;
                er++;
            end
        end
    endfunction

    task automatic do_run(input vec_t v, input string nm);
        int tr, er, fi, dj, ln;
        bit ab;
        int nl = 0;
        bit rec = 1'b0;
        int got_done = -1;
        int idx;
        model(v, tr, er, fi, ab, dj, ln);
        @(negedge clk);
        start        = 1'b1;
        trial_count  = CW'(v.cnt);
        abort        = v.abort_with_start;
        capture_data = '0;
        @(posedge clk);
        for (int j = 0; j < P * v.cnt + 8; j++) begin
            @(negedge clk);
            start       = (j == v.busy_start_at);
            trial_count = CW'(v.cnt + 7);
            abort       = (j == v.abort_at);
            if (j == 0) chk({nm, " busy_run"}, busy, 1);
            if (rec) begin
                chk($sformatf("%s launch_seq%0d", nm, nl), launch_data, nl % (1 << W));
                rec = 1'b0;
            end
            if (launch_en) begin
                nl++;
                rec = 1'b1;
            end
            idx = nl - 1;
            if (v.zero_mode) capture_data = '0;
            else if (idx >= 0 && idx < 64 && v.badm[idx]) capture_data = ~launch_data;
            else capture_data = launch_data;
            if (done) begin
                got_done = j;
                break;
            end
        end
        chk({nm, " done_cycle"}, got_done, dj);
        chk({nm, " launches"}, nl, ln);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk({nm, " done_pulse"}, done, 0);
        chk({nm, " busy_end"}, busy, 0);
        chk({nm, " trials_done"}, trials_done, v.exp_trials);
        chk({nm, " err_count"}, err_count, v.exp_err);
        if (v.exp_err != 0) chk({nm, " first_err"}, first_err_trial, v.exp_first);
        chk({nm, " aborted"}, aborted, v.exp_aborted);
        chk({nm, " launch_final"}, launch_data, ln % (1 << W));
        // Model cross-check of the table's own expectations.
        chk({nm, " model_trials"}, tr, v.exp_trials);
        chk({nm, " model_err"}, er, v.exp_err);
    endtask

    vec_t tbl[9];

    initial begin
        vec_t v;
        int tr, er, fi, dj, ln;
        bit ab;
        int t;

        //               cnt zm badm   abt bsy aws  trials err first ab
        tbl[0] = '{3,  0, 64'h0, -1, -1, 0, 3,  0, 0, 0};
        tbl[1] = '{4,  1, 64'h0, -1, -1, 0, 4,  4, 0, 0};
        tbl[2] = '{18, 0, 64'h4, -1, -1, 0, 18, 1, 2, 0};
        tbl[3] = '{5,  0, 64'h0,  5, -1, 0, 1,  0, 0, 1};
        tbl[4] = '{0,  0, 64'h0, -1, -1, 0, 0,  0, 0, 0};
        tbl[5] = '{2,  0, 64'h3,  7, -1, 0, 1,  1, 0, 1};
        tbl[6] = '{2,  0, 64'h2, -1,  2, 0, 2,  1, 1, 0};
        tbl[7] = '{1,  0, 64'h0, -1, -1, 1, 1,  0, 0, 0};
        tbl[8] = '{2,  0, 64'h0,  8, -1, 0, 2,  0, 0, 0};

        #12;
        chk("reset_outputs", {launch_data, launch_en, busy, done, aborted, trials_done,
                              err_count, first_err_trial}, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) do_run(tbl[i], $sformatf("row%0d", i));

        // Reset during the CHECK cycle of the first trial.
        @(negedge clk);
        start       = 1'b1;
        trial_count = CW'(5);
        @(posedge clk);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk("reset_mid", {launch_data, launch_en, busy, done, aborted, trials_done, err_count,
                          first_err_trial}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk($sformatf("no_done_after_reset%0d", j), done | busy, 0);
        end
        do_run(tbl[0], "fresh");

        for (int r = 0; r < 25; r++) begin
            v.cnt              = $urandom_range(0, 20);
            v.zero_mode        = ($urandom_range(0, 7) == 0);
            v.badm             = {$urandom, $urandom};
            v.abort_with_start = $urandom_range(0, 1);
            v.busy_start_at    = ($urandom_range(0, 1) == 1 && v.cnt > 0) ?
                                 $urandom_range(0, P * v.cnt - 1) : -1;
            if ($urandom_range(0, 1) == 1) begin
                v.abort_at = -1;
            end else begin
                t          = $urandom_range(0, v.cnt);
                v.abort_at = P * t + $urandom_range(1, P - 1);
            end
            model(v, tr, er, fi, ab, dj, ln);
            v.exp_trials  = tr;
            v.exp_err     = er;
            v.exp_first   = fi;
            v.exp_aborted = ab;
            do_run(v, $sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_trial_sequencer.md
SYNC_TRIAL_SEQUENCER -- requirements
Module: sync_trial_sequencer

Interface
REQ-001 Parameter WIDTH, default 4, width of the launched/captured test word.
REQ-002 Parameter CNT_W, default 16, width of the trial and error counters.
REQ-003 Parameter SETTLE_CYCLES, default 2 (legal 1..15), cycles waited between launch and check.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request a run; sampled only in IDLE.
REQ-007 abort  input  1  terminate the current run; ignored in IDLE.
REQ-008 trial_count  input  CNT_W  number of trials; latched on start acceptance.
REQ-009 capture_data  input  WIDTH  synchronized word returned from the synchronizer under test.
REQ-010 launch_data  output  WIDTH  registered test word driven into the source-domain register.
REQ-011 launch_en  output  1  high for exactly the LAUNCH cycle of each trial.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse marking run end.
REQ-014 aborted  output  1  set when a run ends by abort; cleared on the next accepted start.
REQ-015 trials_done  output  CNT_W  completed (checked) trials in the current/last run.
REQ-016 err_count  output  CNT_W  mismatching trials, saturating at all-ones.
REQ-017 first_err_trial  output  CNT_W  0-based index of the first mismatching trial; valid when err_count != 0.

Function
REQ-018 FSM states: IDLE, LAUNCH, SETTLE, CHECK, DONE; one state per cycle except SETTLE.
REQ-019 IDLE: start=1 and trial_count!=0 -> LAUNCH; start=1 and trial_count==0 -> DONE; otherwise stay.
REQ-020 Start acceptance clears launch_data, trials_done, err_count, first_err_trial, and aborted, and latches trial_count.
REQ-021 LAUNCH: launch_data <= launch_data+1 (wraps mod 2^WIDTH), launch_en=1, next state SETTLE.
REQ-022 SETTLE: held exactly SETTLE_CYCLES cycles via internal down-counter, then CHECK.
REQ-023 CHECK: capture_data != launch_data -> err_count+1 (saturating); if err_count was 0, first_err_trial <= trials_done.
REQ-024 CHECK: trials_done+1; next state DONE if the new trials_done equals the latched count, else LAUNCH.
REQ-025 Trial period is SETTLE_CYCLES+2 cycles; with start accepted at edge 0, done is high in the cycle after edge N*(SETTLE_CYCLES+2)+1.
REQ-026 DONE: done=1 for one cycle, then IDLE; result outputs hold until the next accepted start.
REQ-027 abort=1 in LAUNCH, SETTLE, or CHECK -> DONE next edge, aborted<=1; the CHECK in progress is not counted.
REQ-028 abort in DONE has no effect; abort and start together in IDLE -> start accepted.
REQ-029 start while busy is ignored and does not alter the latched trial_count.
REQ-030 launch_data holds its value outside LAUNCH; capture_data is sampled only in CHECK.
REQ-031 trials_done never exceeds the latched trial_count; err_count never exceeds trials_done except at saturation.

Reset
REQ-032 rst=1 asynchronously forces IDLE and zeroes launch_data, launch_en, busy, done, aborted, trials_done, err_count, first_err_trial, and the settle counter.
REQ-033 rst asserted mid-run discards the run; no done pulse is generated on reset or release.
REQ-034 The first start is accepted on the first rising edge after rst deasserts.

Verification
REQ-035 Loopback (capture_data=launch_data), trial_count=3, SETTLE=2 -> launch_data 1,2,3; done after edge 13; trials_done=3, err_count=0.
REQ-036 capture_data forced to 0, trial_count=4 -> err_count=4, first_err_trial=0, trials_done=4.
REQ-037 Loopback except trial 2 corrupted, trial_count=18, WIDTH=4 -> launch_data wraps 15->0; err_count=1, first_err_trial=2.
REQ-038 abort asserted in SETTLE of trial 1, trial_count=5 -> done next cycle, aborted=1, trials_done=1.
REQ-039 trial_count=0 start -> done pulse after 1 edge, launch_en never asserts, all counts 0.
REQ-040 rst pulsed in CHECK -> all outputs 0 immediately, no done; a fresh start runs normally.
